rule110_row_serializer: RTL

- Downstream stage of the rule-110 generation engine.
- Accepts one complete 256-bit automaton row per valid/ready handshake.
- Streams each row out as sixteen 16-bit words, MSB word first, to the 16-bit pin group `{uo_out, uio_out}`.
- Double-buffered: the engine can hand over generation N+1 while generation N is still draining.
- Keeps a generation counter for the test harness.

---
 rtl/rule110_pkg.sv | 26 ++
 rtl/rule110_row_buf.sv | 79 +++++++
 rtl/rule110_row_serializer.sv | 81 ++++++++
 3 files changed

// File: rtl/rule110_pkg.sv
// Shared constants and helpers for the rule-110 generation engine and its
// row serializer.
package rule110_pkg;

  localparam int unsigned ROW_W  = 256;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned CNT_W  = 16;

  // Occupancy of the two-entry row buffer, decoded from its fill flags.
  typedef enum logic [1:0] {
    BUF_EMPTY  = 2'd0,
    BUF_STREAM = 2'd1,
    BUF_FULL   = 2'd2
  } buf_state_e;

  // Word idx of a row, MSB word first: idx 0 is row[ROW_W-1 -: WORD_W].
  function automatic logic [WORD_W-1:0] row_word(input logic [ROW_W-1:0] row,
                                                 input logic [IDX_W-1:0] idx);
    int unsigned base;
    base = ROW_W - 1 - WORD_W * int'(idx);
    return row[base -: WORD_W];
  endfunction

endpackage

// File: rtl/rule110_row_buf.sv
// Two-entry row skid buffer: an active row being drained and a pending row
// waiting behind it. The consumer pops the active row when its last word
// leaves; a pending row then moves up without a bubble.
module rule110_row_buf
  import rule110_pkg::*;
#(
  parameter int unsigned DATA_W = ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_pop,
  output logic [DATA_W-1:0] out_data
);

  logic              r_act_full;
  logic              r_pend_full;
  logic [DATA_W-1:0] r_active;
  logic [DATA_W-1:0] r_pending;
  logic              w_accept;
  buf_state_e        w_state;

  assign in_ready  = !r_pend_full;
  assign w_accept  = in_valid && !r_pend_full;
  assign out_valid = r_act_full;
  assign out_data  = r_active;

  // Decode occupancy from the fill flags; act=0/pend=1 cannot occur.
  always_comb begin
    w_state = BUF_EMPTY;
    if (r_act_full) begin
      w_state = r_pend_full ? BUF_FULL : BUF_STREAM;
    end
  end

  // Load, move and release rows; data registers need no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_full  <= 1'b0;
      r_pend_full <= 1'b0;
    end else begin
      case (w_state)
        BUF_EMPTY: begin
          if (w_accept) begin
            r_active   <= in_data;
            r_act_full <= 1'b1;
          end
        end
        BUF_STREAM: begin
          if (out_pop) begin
            // Row leaving: a row arriving on the same edge replaces it directly.
            if (w_accept) begin
              r_active <= in_data;
            end else begin
              r_act_full <= 1'b0;
            end
          end else if (w_accept) begin
            r_pending   <= in_data;
            r_pend_full <= 1'b1;
          end
        end
        BUF_FULL: begin
          if (out_pop) begin
            r_active    <= r_pending;
            r_pend_full <= 1'b0;
          end
        end
        default: begin
          r_act_full  <= 1'b0;
          r_pend_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rule110_row_serializer.sv
// Streams 256-bit automaton rows out as sixteen 16-bit words, MSB word
// first, with a double-buffered row input and a completed-row counter.
module rule110_row_serializer
  import rule110_pkg::*;
#(
  parameter int unsigned ROW_W  = rule110_pkg::ROW_W,
  parameter int unsigned WORD_W = rule110_pkg::WORD_W,
  parameter int unsigned WORDS  = rule110_pkg::WORDS,
  parameter int unsigned CNT_W  = rule110_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  row_data,
  input  logic              row_valid,
  output logic              row_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [IDX_W-1:0]  word_idx,
  output logic              sof,
  output logic              eof,
  output logic [CNT_W-1:0]  gen_count
);

  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_gen_count;
  logic             w_act_valid;
  logic [ROW_W-1:0] w_act_data;
  logic             w_xfer;
  logic             w_last;
  logic             w_pop;

  assign w_xfer = w_act_valid && word_ready;
  assign w_last = (r_idx == IDX_W'(WORDS - 1));
  assign w_pop  = w_xfer && w_last;

  rule110_row_buf #(
    .DATA_W (ROW_W)
  ) u_row_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (row_valid),
    .in_ready  (row_ready),
    .in_data   (row_data),
    .out_valid (w_act_valid),
    .out_pop   (w_pop),
    .out_data  (w_act_data)
  );

  // Advance the word index per transfer and count completed rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_gen_count <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_idx       <= '0;
        r_gen_count <= r_gen_count + CNT_W'(1);
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Word mux and framing flags, forced low while nothing is buffered.
  always_comb begin
    word_valid = w_act_valid;
    word_idx   = r_idx;
    word_data  = '0;
    sof        = 1'b0;
    eof        = 1'b0;
    if (w_act_valid) begin
      word_data = row_word(w_act_data, r_idx);
      sof       = (r_idx == '0);
      eof       = w_last;
    end
  end

  assign gen_count = r_gen_count;

endmodule
